// File: rtl/inv_mixcol.sv
// Inverse AES MixColumns, iterating COLS_PER_CYCLE columns per clock over a latched 128-bit state.
// Optional macro INV_MIXCOL_BUSY_EN adds a registered inv_mixcol_busy output.
module inv_mixcol #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inv_mixcol_enable,
  input  logic [127:0] olddata,
  output logic [127:0] newdata,
  output logic         inv_mixcol_finished
`ifdef INV_MIXCOL_BUSY_EN
  ,
  output logic         inv_mixcol_busy
`endif
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("inv_mixcol: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

  state_t       state, state_nxt;
  logic [1:0]   cnt;
  logic [127:0] work, work_nxt;
  logic         last_cols;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column packed as {s0, s1, s2, s3}; 0e/0b/0d/09 circulant built from xtime chains.
  function automatic logic [31:0] inv_col(input logic [31:0] col);
    logic [7:0]  b, x2, x4, x8;
    logic [7:0]  m9 [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  me [4];
    logic [31:0] res;
    logic [1:0]  r0, r1, r2, r3;
    for (int r = 0; r < 4; r++) begin
      b  = col[31-8*r -: 8];
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      r0 = 2'(r);
      m9[r0] = x8 ^ b;
      mb[r0] = x8 ^ x2 ^ b;
      md[r0] = x8 ^ x4 ^ b;
      me[r0] = x8 ^ x4 ^ x2;
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      r0 = 2'(r);
      r1 = r0 + 2'd1;
      r2 = r0 + 2'd2;
      r3 = r0 + 2'd3;
      res[31-8*r -: 8] = me[r0] ^ mb[r1] ^ md[r2] ^ m9[r3];
    end
    return res;
  endfunction

  always_comb begin
    logic [31:0] col;
    logic [31:0] res;
    int          c;
    work_nxt = work;
    col      = '0;
    res      = '0;
    c        = 0;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      c = int'(cnt) + k;
      for (int r = 0; r < 4; r++)
        col[31-8*r -: 8] = work[127-8*(4*r+c) -: 8];
      res = inv_col(col);
      for (int r = 0; r < 4; r++)
        work_nxt[127-8*(4*r+c) -: 8] = res[31-8*r -: 8];
    end
  end

  assign last_cols = (int'(cnt) + COLS_PER_CYCLE == 4);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inv_mixcol_enable) state_nxt = CALC;
      CALC:    if (last_cols) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Working register only moves in CALC; newdata is written once, with every column done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work    <= '0;
      cnt     <= '0;
      newdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inv_mixcol_enable) begin
            work <= olddata;
            cnt  <= '0;
          end
        end
        CALC: begin
          work <= work_nxt;
          cnt  <= cnt + STEP;
          if (last_cols) newdata <= work_nxt;
        end
        default: ;
      endcase
    end
  end

  assign inv_mixcol_finished = (state == DONE);

`ifdef INV_MIXCOL_BUSY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inv_mixcol_busy <= 1'b0;
    else     inv_mixcol_busy <= (state_nxt != IDLE);
  end
`endif

endmodule
